// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit id encodings, field widths and input-port FSM states.
package noc_pkg;

  localparam int unsigned ID_W  = 3;
  localparam int unsigned LEN_W = 12;

  localparam logic [ID_W-1:0] FLIT_HEAD   = 3'b001;
  localparam logic [ID_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [ID_W-1:0] FLIT_TAIL   = 3'b100;
  localparam logic [ID_W-1:0] FLIT_SINGLE = 3'b101;

  typedef enum logic [0:0] {StIdle, StActive} port_state_e;

  // flit_id occupies the top ID_W bits of a flit
  function automatic int unsigned flit_id_lsb(input int unsigned data_w);
    return data_w - ID_W;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit FIFO with registered occupancy count; head entry is visible combinationally.
module flit_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CntW-1:0]   count_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // At full only a pop can happen; a pop on empty is ignored
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/input_port_buffer.sv
// Router input stage: buffers flits, enforces packet framing, requests the arbiter and
// pops towards the crossbar on grant. Flits out of framing are discarded with drop_err.
module input_port_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ID_W   = noc_pkg::ID_W,
  parameter int unsigned LEN_W  = noc_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_flit,
  output logic              in_ready,
  input  logic              grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_flit,
  output logic              req,
  output logic [ID_W-1:0]   flit_id,
  output logic [LEN_W-1:0]  length,
  output logic              drop_err
);
  import noc_pkg::*;

  localparam int unsigned IdLsb = flit_id_lsb(DATA_W);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [ID_W-1:0]   head_id;
  logic              is_start, is_cont, legal_head, pop, drop;
  port_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              drop_err_q;
  logic              unused_count;

  flit_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .data_i  (in_flit),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign unused_count = ^fifo_count;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  assign head_id  = fifo_head[IdLsb +: ID_W];
  assign is_start = (head_id == FLIT_HEAD) | (head_id == FLIT_SINGLE);
  assign is_cont  = (head_id == FLIT_BODY) | (head_id == FLIT_TAIL);

  // A packet may only open in IDLE and only continue in ACTIVE; anything else is an orphan
  assign legal_head = (state_q == StIdle) ? is_start : is_cont;
  assign req        = ~fifo_empty & legal_head;
  assign pop        = grant & req;
  assign drop       = ~fifo_empty & ~legal_head;
  assign fifo_pop   = pop | drop;

  assign out_valid = pop;
  assign out_flit  = fifo_head;
  assign flit_id   = fifo_empty ? '0 : head_id;
  assign length    = (~fifo_empty & is_start) ? fifo_head[LEN_W-1:0] : len_q;
  assign drop_err  = drop_err_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (pop && is_start) len_d = fifo_head[LEN_W-1:0];
    unique case (state_q)
      StIdle:   if (pop && head_id == FLIT_HEAD) state_d = StActive;
      StActive: if (pop && head_id == FLIT_TAIL) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      drop_err_q <= drop;
    end
  end

endmodule
